// File: rtl/axi4l_arbiter2.sv
// Two-requester AXI4-Lite arbiter in front of a single shared AXI4-Lite slave.
// Exactly one transaction is in flight at a time: an IDLE cycle picks a master
// (round-robin or fixed priority) and a direction. The request channels are then
// passed through combinationally to the slave, and the response is routed back
// to the granted master only.
module axi4l_arbiter2 #(
    parameter bit rr       = 1'b1,  // 1: round-robin, 0: m0 always wins
    parameter bit wr_first = 1'b1,  // same master with write+read pending: 1 = write first
    parameter int ADDR_W   = 32
) (
    input  logic              aclk,
    input  logic              areset,
    // requester 0
    input  logic              m0_awvalid,
    output logic              m0_awready,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic              m0_wvalid,
    output logic              m0_wready,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_bvalid,
    input  logic              m0_bready,
    output logic [1:0]        m0_bresp,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [31:0]       m0_rdata,
    output logic [1:0]        m0_rresp,
    // requester 1
    input  logic              m1_awvalid,
    output logic              m1_awready,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic              m1_wvalid,
    output logic              m1_wready,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_bvalid,
    input  logic              m1_bready,
    output logic [1:0]        m1_bresp,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [31:0]       m1_rdata,
    output logic [1:0]        m1_rresp,
    // shared slave
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_wvalid,
    input  logic              s_wready,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_wstrb,
    input  logic              s_bvalid,
    output logic              s_bready,
    input  logic [1:0]        s_bresp,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [31:0]       s_rdata,
    input  logic [1:0]        s_rresp
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WREQ  = 3'd1,
        WRESP = 3'd2,
        RREQ  = 3'd3,
        RRESP = 3'd4
    } state_t;

    state_t state_reg, state_next;
    logic   gnt_reg, gnt_next;          // currently granted master
    logic   last_reg, last_next;        // master that completed the last transaction
    logic   aw_done_reg, aw_done_next;  // AW already accepted by the slave in this write
    logic   w_done_reg, w_done_next;    // W already accepted by the slave in this write

    // Requester inputs gathered into index-by-master form
    logic [1:0]        m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
    logic [ADDR_W-1:0] m_awaddr [2];
    logic [ADDR_W-1:0] m_araddr [2];
    logic [31:0]       m_wdata  [2];
    logic [3:0]        m_wstrb  [2];

    // Requester outputs in index-by-master form
    logic [1:0]        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [1:0]        m_bresp  [2];
    logic [31:0]       m_rdata  [2];
    logic [1:0]        m_rresp  [2];

    assign m_awvalid   = {m1_awvalid, m0_awvalid};
    assign m_wvalid    = {m1_wvalid,  m0_wvalid};
    assign m_arvalid   = {m1_arvalid, m0_arvalid};
    assign m_bready    = {m1_bready,  m0_bready};
    assign m_rready    = {m1_rready,  m0_rready};
    assign m_awaddr[0] = m0_awaddr;
    assign m_awaddr[1] = m1_awaddr;
    assign m_araddr[0] = m0_araddr;
    assign m_araddr[1] = m1_araddr;
    assign m_wdata[0]  = m0_wdata;
    assign m_wdata[1]  = m1_wdata;
    assign m_wstrb[0]  = m0_wstrb;
    assign m_wstrb[1]  = m1_wstrb;

    assign m0_awready = m_awready[0];
    assign m1_awready = m_awready[1];
    assign m0_wready  = m_wready[0];
    assign m1_wready  = m_wready[1];
    assign m0_bvalid  = m_bvalid[0];
    assign m1_bvalid  = m_bvalid[1];
    assign m0_arready = m_arready[0];
    assign m1_arready = m_arready[1];
    assign m0_rvalid  = m_rvalid[0];
    assign m1_rvalid  = m_rvalid[1];
    assign m0_bresp   = m_bresp[0];
    assign m1_bresp   = m_bresp[1];
    assign m0_rdata   = m_rdata[0];
    assign m1_rdata   = m_rdata[1];
    assign m0_rresp   = m_rresp[0];
    assign m1_rresp   = m_rresp[1];

    logic st_wreq, st_wresp, st_rreq, st_rresp;
    assign st_wreq  = (state_reg == WREQ);
    assign st_wresp = (state_reg == WRESP);
    assign st_rreq  = (state_reg == RREQ);
    assign st_rresp = (state_reg == RRESP);

    // Slave-side request/response-ready, taken from the granted master only
    assign s_awvalid = st_wreq && m_awvalid[gnt_reg] && !aw_done_reg;
    assign s_wvalid  = st_wreq && m_wvalid[gnt_reg] && !w_done_reg;
    assign s_awaddr  = st_wreq ? m_awaddr[gnt_reg] : '0;
    assign s_wdata   = st_wreq ? m_wdata[gnt_reg]  : '0;
    assign s_wstrb   = st_wreq ? m_wstrb[gnt_reg]  : '0;
    assign s_bready  = st_wresp && m_bready[gnt_reg];
    assign s_arvalid = st_rreq && m_arvalid[gnt_reg];
    assign s_araddr  = st_rreq ? m_araddr[gnt_reg] : '0;
    assign s_rready  = st_rresp && m_rready[gnt_reg];

    // Requester-side readies and responses; everything is zero unless granted and in the matching state
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic sel;
            assign sel           = (gnt_reg == 1'(gi));
            assign m_awready[gi] = sel && st_wreq && s_awready && !aw_done_reg;
            assign m_wready[gi]  = sel && st_wreq && s_wready && !w_done_reg;
            assign m_bvalid[gi]  = sel && st_wresp && s_bvalid;
            assign m_bresp[gi]   = (sel && st_wresp) ? s_bresp : '0;
            assign m_arready[gi] = sel && st_rreq && s_arready;
            assign m_rvalid[gi]  = sel && st_rresp && s_rvalid;
            assign m_rdata[gi]   = (sel && st_rresp) ? s_rdata : '0;
            assign m_rresp[gi]   = (sel && st_rresp) ? s_rresp : '0;
        end
    endgenerate

    // Arbitration inputs: a write needs both AW and W valid, a read only AR
    logic [1:0] req_w, req_r, req;
    logic       pref, pick, go_write;
    assign req_w    = m_awvalid & m_wvalid;
    assign req_r    = m_arvalid;
    assign req      = req_w | req_r;
    assign pref     = rr ? ~last_reg : 1'b0;
    assign pick     = req[pref] ? pref : ~pref;
    assign go_write = req_w[pick] && (!req_r[pick] || wr_first);

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign b_hs  = s_bvalid && s_bready;
    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = s_rvalid && s_rready;

    // Next-state logic: arbitrate in IDLE, then track handshakes of the granted transaction
    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        last_next    = last_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    gnt_next   = pick;
                    state_next = go_write ? WREQ : RREQ;
                end
            end
            WREQ: begin
                // AW and W may complete in either order or in the same cycle
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    state_next   = WRESP;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end else begin
                    aw_done_next = aw_done_reg || aw_hs;
                    w_done_next  = w_done_reg || w_hs;
                end
            end
            WRESP: begin
                if (b_hs) begin
                    last_next  = gnt_reg;
                    state_next = IDLE;
                end
            end
            RREQ: begin
                if (ar_hs) begin
                    state_next = RRESP;
                end
            end
            RRESP: begin
                if (r_hs) begin
                    last_next  = gnt_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers; last starts at 1 so that m0 has priority after reset
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg   <= IDLE;
            gnt_reg     <= 1'b0;
            last_reg    <= 1'b1;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            last_reg    <= last_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
        end
    end

endmodule

// File: tb/tb_axi4l_arbiter2.sv
// Directed bench for axi4l_arbiter2: a cycle table on a round-robin/write-first
// instance, then hand-written sequences for split writes, mid-transaction reset
// and fixed priority on a second (rr=0, wr_first=0) instance.
module tb_axi4l_arbiter2;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    // shared stimulus
    logic [1:0]  m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
    logic [31:0] m0_awaddr, m1_awaddr, m0_araddr, m1_araddr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;

    // outputs of the round-robin instance (a_) and fixed-priority instance (f_)
    logic [1:0]  a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
    logic [1:0]  a_bresp0, a_bresp1, a_rresp0, a_rresp1;
    logic [31:0] a_rdata0, a_rdata1, a_s_awaddr, a_s_wdata, a_s_araddr;
    logic [3:0]  a_s_wstrb;
    logic        a_s_awvalid, a_s_wvalid, a_s_bready, a_s_arvalid, a_s_rready;
    logic [1:0]  f_awready, f_wready, f_bvalid, f_arready, f_rvalid;
    logic [1:0]  f_bresp0, f_bresp1, f_rresp0, f_rresp1;
    logic [31:0] f_rdata0, f_rdata1, f_s_awaddr, f_s_wdata, f_s_araddr;
    logic [3:0]  f_s_wstrb;
    logic        f_s_awvalid, f_s_wvalid, f_s_bready, f_s_arvalid, f_s_rready;

    axi4l_arbiter2 #(.rr(1'b1), .wr_first(1'b1), .ADDR_W(32)) dut (
        .aclk(aclk), .areset(areset),
        .m0_awvalid(m_awvalid[0]), .m0_awready(a_awready[0]), .m0_awaddr(m0_awaddr),
        .m0_wvalid(m_wvalid[0]), .m0_wready(a_wready[0]), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_bvalid(a_bvalid[0]), .m0_bready(m_bready[0]), .m0_bresp(a_bresp0),
        .m0_arvalid(m_arvalid[0]), .m0_arready(a_arready[0]), .m0_araddr(m0_araddr),
        .m0_rvalid(a_rvalid[0]), .m0_rready(m_rready[0]), .m0_rdata(a_rdata0), .m0_rresp(a_rresp0),
        .m1_awvalid(m_awvalid[1]), .m1_awready(a_awready[1]), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m_wvalid[1]), .m1_wready(a_wready[1]), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(a_bvalid[1]), .m1_bready(m_bready[1]), .m1_bresp(a_bresp1),
        .m1_arvalid(m_arvalid[1]), .m1_arready(a_arready[1]), .m1_araddr(m1_araddr),
        .m1_rvalid(a_rvalid[1]), .m1_rready(m_rready[1]), .m1_rdata(a_rdata1), .m1_rresp(a_rresp1),
        .s_awvalid(a_s_awvalid), .s_awready(s_awready), .s_awaddr(a_s_awaddr),
        .s_wvalid(a_s_wvalid), .s_wready(s_wready), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(a_s_bready), .s_bresp(s_bresp),
        .s_arvalid(a_s_arvalid), .s_arready(s_arready), .s_araddr(a_s_araddr),
        .s_rvalid(s_rvalid), .s_rready(a_s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
    );

    axi4l_arbiter2 #(.rr(1'b0), .wr_first(1'b0), .ADDR_W(32)) dut_fp (
        .aclk(aclk), .areset(areset),
        .m0_awvalid(m_awvalid[0]), .m0_awready(f_awready[0]), .m0_awaddr(m0_awaddr),
        .m0_wvalid(m_wvalid[0]), .m0_wready(f_wready[0]), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_bvalid(f_bvalid[0]), .m0_bready(m_bready[0]), .m0_bresp(f_bresp0),
        .m0_arvalid(m_arvalid[0]), .m0_arready(f_arready[0]), .m0_araddr(m0_araddr),
        .m0_rvalid(f_rvalid[0]), .m0_rready(m_rready[0]), .m0_rdata(f_rdata0), .m0_rresp(f_rresp0),
        .m1_awvalid(m_awvalid[1]), .m1_awready(f_awready[1]), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m_wvalid[1]), .m1_wready(f_wready[1]), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(f_bvalid[1]), .m1_bready(m_bready[1]), .m1_bresp(f_bresp1),
        .m1_arvalid(m_arvalid[1]), .m1_arready(f_arready[1]), .m1_araddr(m1_araddr),
        .m1_rvalid(f_rvalid[1]), .m1_rready(m_rready[1]), .m1_rdata(f_rdata1), .m1_rresp(f_rresp1),
        .s_awvalid(f_s_awvalid), .s_awready(s_awready), .s_awaddr(f_s_awaddr),
        .s_wvalid(f_s_wvalid), .s_wready(s_wready), .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(f_s_bready), .s_bresp(s_bresp),
        .s_arvalid(f_s_arvalid), .s_arready(s_arready), .s_araddr(f_s_araddr),
        .s_rvalid(s_rvalid), .s_rready(f_s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
    );

    // 15-bit handshake view: {awready, wready, bvalid, arready, rvalid} per master, then slave side
    logic [14:0] a_obs, f_obs;
    assign a_obs = {a_awready, a_wready, a_bvalid, a_arready, a_rvalid,
                    a_s_awvalid, a_s_wvalid, a_s_bready, a_s_arvalid, a_s_rready};
    assign f_obs = {f_awready, f_wready, f_bvalid, f_arready, f_rvalid,
                    f_s_awvalid, f_s_wvalid, f_s_bready, f_s_arvalid, f_s_rready};

    // handshake counters on the round-robin instance's slave port
    int aw_cnt = 0;
    int w_cnt  = 0;
    always @(posedge aclk) begin
        if (a_s_awvalid && s_awready) aw_cnt++;
        if (a_s_wvalid && s_wready)   w_cnt++;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [1:0]  awv, wv, arv, br, rr;
        logic [4:0]  s;     // {awready, wready, bvalid, arready, rvalid}
        logic [14:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] awv, wv, arv, br, rr, input logic [4:0] s,
                                input logic [1:0] e_awr, e_wr, e_bv, e_arr, e_rv, input logic [4:0] e_s);
        vec_t v;
        v.awv = awv; v.wv = wv; v.arv = arv; v.br = br; v.rr = rr; v.s = s;
        v.exp = {e_awr, e_wr, e_bv, e_arr, e_rv, e_s};
        return v;
    endfunction

    task automatic idle_inputs();
        m_awvalid = 2'b00; m_wvalid = 2'b00; m_arvalid = 2'b00;
        m_bready = 2'b00; m_rready = 2'b00;
        {s_awready, s_wready, s_bvalid, s_arready, s_rvalid} = 5'b00000;
        s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = 32'h0;
    endtask

    task automatic do_reset(input string name);
        @(negedge aclk);
        idle_inputs();
        areset = 1'b1;
        #1;
        chk({name, "_rst_a"}, 64'(a_obs), 64'h0);
        chk({name, "_rst_f"}, 64'(f_obs), 64'h0);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    vec_t tbl[28];

    initial begin
        m0_awaddr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF; m0_araddr = 32'h10;
        m1_awaddr = 32'h20; m1_wdata = 32'h12345678; m1_wstrb = 4'h3; m1_araddr = 32'h24;
        idle_inputs();

        //          awv    wv     arv    br     rr     s_in      e_awr  e_wr   e_bv   e_arr  e_rv   e_s
        tbl[0]  = mk(2'b00,2'b00,2'b00,2'b00,2'b00,5'b00000, 2'b00,2'b00,2'b00,2'b00,2'b00,5'b00000);
        // single m0 write then read
        tbl[1]  = mk(2'b01,2'b01,2'b00,2'b00,2'b00,5'b00000, 2'b00,2'b00,2'b00,2'b00,2'b00,5'b00000);
        tbl[2]  = mk(2'b01,2'b01,2'b00,2'b00,2'b00,5'b11000, 2'b01,2'b01,2'b00,2'b00,2'b00,5'b11000);
        tbl[3]  = mk(2'b00,2'b00,2'b00,2'b01,2'b00,5'b00100, 2'b00,2'b00,2'b01,2'b00,2'b00,5'b00100);
        tbl[4]  = mk(2'b00,2'b00,2'b01,2'b00,2'b00,5'b00000, 2'b00,2'b00,2'b00,2'b00,2'b00,5'b00000);
        tbl[5]  = mk(2'b00,2'b00,2'b01,2'b00,2'b00,5'b00010, 2'b00,2'b00,2'b00,2'b01,2'b00,5'b00010);
        tbl[6]  = mk(2'b00,2'b00,2'b00,2'b00,2'b01,5'b00001, 2'b00,2'b00,2'b00,2'b00,2'b01,5'b00001);
        // read contention: last=0 so m1 first, then m0
        tbl[7]  = mk(2'b00,2'b00,2'b11,2'b00,2'b00,5'b00000, 2'b00,2'b00,2'b00,2'b00,2'b00,5'b00000);
        tbl[8]  = mk(2'b00,2'b00,2'b11,2'b00,2'b00,5'b00010, 2'b00,2'b00,2'b00,2'b10,2'b00,5'b00010);
        tbl[9]  = mk(2'b00,2'b00,2'b01,2'b00,2'b10,5'b00001, 2'b00,2'b00,2'b00,2'b00,2'b10,5'b00001);
        tbl[10] = mk(2'b00,2'b00,2'b01,2'b00,2'b00,5'b00000, 2'b00,2'b00,2'b00,2'b00,2'b00,5'b00000);
        tbl[11] = mk(2'b00,2'b00,2'b01,2'b00,2'b00,5'b00010, 2'b00,2'b00,2'b00,2'b01,2'b00,5'b00010);
        tbl[12] = mk(2'b00,2'b00,2'b00,2'b00,2'b01,5'b00001, 2'b00,2'b00,2'b00,2'b00,2'b01,5'b00001);
        // spurious slave responses in IDLE, split m1 write, B backpressure with m0 waiting
        tbl[13] = mk(2'b10,2'b10,2'b00,2'b00,2'b00,5'b00101, 2'b00,2'b00,2'b00,2'b00,2'b00,5'b00000);
        tbl[14] = mk(2'b10,2'b10,2'b00,2'b00,2'b00,5'b10000, 2'b10,2'b00,2'b00,2'b00,2'b00,5'b11000);
        tbl[15] = mk(2'b10,2'b10,2'b00,2'b00,2'b00,5'b11000, 2'b00,2'b10,2'b00,2'b00,2'b00,5'b01000);
        tbl[16] = mk(2'b00,2'b00,2'b01,2'b00,2'b00,5'b00100, 2'b00,2'b00,2'b10,2'b00,2'b00,5'b00000);
        tbl[17] = mk(2'b00,2'b00,2'b01,2'b00,2'b00,5'b00100, 2'b00,2'b00,2'b10,2'b00,2'b00,5'b00000);
        tbl[18] = mk(2'b00,2'b00,2'b01,2'b10,2'b00,5'b00100, 2'b00,2'b00,2'b10,2'b00,2'b00,5'b00100);
        tbl[19] = mk(2'b00,2'b00,2'b01,2'b00,2'b00,5'b00000, 2'b00,2'b00,2'b00,2'b00,2'b00,5'b00000);
        tbl[20] = mk(2'b00,2'b00,2'b01,2'b00,2'b00,5'b00010, 2'b00,2'b00,2'b00,2'b01,2'b00,5'b00010);
        tbl[21] = mk(2'b00,2'b00,2'b00,2'b00,2'b01,5'b00001, 2'b00,2'b00,2'b00,2'b00,2'b01,5'b00001);
        // m1 presents write and read together: write goes first
        tbl[22] = mk(2'b10,2'b10,2'b10,2'b00,2'b00,5'b00000, 2'b00,2'b00,2'b00,2'b00,2'b00,5'b00000);
        tbl[23] = mk(2'b10,2'b10,2'b10,2'b00,2'b00,5'b11000, 2'b10,2'b10,2'b00,2'b00,2'b00,5'b11000);
        tbl[24] = mk(2'b00,2'b00,2'b10,2'b10,2'b00,5'b00100, 2'b00,2'b00,2'b10,2'b00,2'b00,5'b00100);
        tbl[25] = mk(2'b00,2'b00,2'b10,2'b00,2'b00,5'b00000, 2'b00,2'b00,2'b00,2'b00,2'b00,5'b00000);
        tbl[26] = mk(2'b00,2'b00,2'b10,2'b00,2'b00,5'b00010, 2'b00,2'b00,2'b00,2'b10,2'b00,5'b00010);
        tbl[27] = mk(2'b00,2'b00,2'b00,2'b00,2'b10,5'b00001, 2'b00,2'b00,2'b00,2'b00,2'b10,5'b00001);

        do_reset("init");

        for (int i = 0; i < 28; i++) begin
            @(negedge aclk);
            m_awvalid = tbl[i].awv; m_wvalid = tbl[i].wv; m_arvalid = tbl[i].arv;
            m_bready = tbl[i].br; m_rready = tbl[i].rr;
            {s_awready, s_wready, s_bvalid, s_arready, s_rvalid} = tbl[i].s;
            #1;
            chk($sformatf("vec%0d", i), 64'(a_obs), 64'(tbl[i].exp));
            $display("vec%0d obs=%h exp=%h", i, a_obs, tbl[i].exp);
        end

        // split write: AW without W is not a request; W first, AW two cycles later
        do_reset("split");
        begin
            int aw0, w0;
            aw0 = aw_cnt; w0 = w_cnt;
            for (int c = 0; c < 3; c++) begin
                @(negedge aclk); m_awvalid = 2'b10; #1;
                chk($sformatf("split_noreq%0d", c), 64'(a_obs), 64'h0);
            end
            @(negedge aclk); m_wvalid = 2'b10; #1;
            chk("split_idle", 64'(a_obs), 64'h0);
            @(negedge aclk); s_wready = 1'b1; #1;
            chk("split_w", 64'(a_obs), 64'h0_0000 | {2'b00, 2'b10, 6'b0, 5'b11000});
            chk("split_awaddr", 64'(a_s_awaddr), 64'h20);
            chk("split_wdata", 64'({a_s_wstrb, a_s_wdata}), 64'h3_12345678);
            @(negedge aclk); m_wvalid = 2'b00; s_awready = 1'b1; #1;
            chk("split_aw", 64'(a_obs), 64'({2'b10, 2'b00, 6'b0, 5'b10000}));
            @(negedge aclk); m_awvalid = 2'b00; s_awready = 1'b0; s_wready = 1'b0;
            s_bvalid = 1'b1; s_bresp = 2'b10; m_bready = 2'b10; #1;
            chk("split_b", 64'(a_obs), 64'({4'b0, 2'b10, 4'b0, 5'b00100}));
            chk("split_bresp", 64'({a_bresp1, a_bresp0}), 64'b1000);
            @(negedge aclk); idle_inputs(); #1;
            chk("split_aw_cnt", 64'(aw_cnt - aw0), 64'd1);
            chk("split_w_cnt", 64'(w_cnt - w0), 64'd1);
            $display("split write: aw=%0d w=%0d", aw_cnt - aw0, w_cnt - w0);
        end

        // reset while waiting in WRESP, then m0 wins the first arbitration again
        do_reset("midrst");
        @(negedge aclk); m_awvalid = 2'b01; m_wvalid = 2'b01;
        @(negedge aclk); s_awready = 1'b1; s_wready = 1'b1;
        @(negedge aclk); idle_inputs(); s_bvalid = 1'b1; #1;
        chk("midrst_wresp", 64'(a_bvalid), 64'b01);
        areset = 1'b1; #1;
        chk("midrst_async", 64'(a_obs), 64'h0);
        @(negedge aclk); areset = 1'b0; idle_inputs();
        m_awvalid = 2'b11; m_wvalid = 2'b11;
        @(negedge aclk); s_awready = 1'b1; s_wready = 1'b1; #1;
        chk("midrst_gnt0", 64'({a_awready, a_wready}), 64'b0101);
        chk("midrst_addr0", 64'(a_s_awaddr), 64'h10);
        @(negedge aclk); m_awvalid = 2'b10; m_wvalid = 2'b10; s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1; m_bready = 2'b01;
        @(negedge aclk); s_bvalid = 1'b0; m_bready = 2'b00;
        @(negedge aclk); s_awready = 1'b1; s_wready = 1'b1; #1;
        chk("midrst_gnt1", 64'({a_awready, a_wready}), 64'b1010);
        chk("midrst_addr1", 64'(a_s_awaddr), 64'h20);
        $display("mid-op reset: m1 granted after m0, addr=%h", a_s_awaddr);

        // fixed priority instance: m0 wins every contention, m1 only when m0 is quiet
        do_reset("fp");
        @(negedge aclk); m_arvalid = 2'b11; #1;
        chk("fp_idle", 64'(f_obs), 64'h0);
        @(negedge aclk); s_arready = 1'b1; #1;
        chk("fp_grant0a", 64'(f_arready), 64'b01);
        chk("fp_araddr", 64'(f_s_araddr), 64'h10);
        @(negedge aclk); s_arready = 1'b0; s_rvalid = 1'b1; m_rready = 2'b01;
        s_rdata = 32'hCAFEF00D; s_rresp = 2'b01; #1;
        chk("fp_rvalid", 64'(f_rvalid), 64'b01);
        chk("fp_rdata", 64'({f_rdata1, f_rdata0}), 64'h00000000_CAFEF00D);
        chk("fp_rresp", 64'({f_rresp1, f_rresp0}), 64'b0001);
        @(negedge aclk); s_rvalid = 1'b0; m_rready = 2'b00;
        @(negedge aclk); s_arready = 1'b1; #1;
        chk("fp_grant0b", 64'(f_arready), 64'b01);
        @(negedge aclk); s_arready = 1'b0; m_arvalid = 2'b10; s_rvalid = 1'b1; m_rready = 2'b01;
        @(negedge aclk); s_rvalid = 1'b0; m_rready = 2'b00;
        @(negedge aclk); s_arready = 1'b1; #1;
        chk("fp_grant1", 64'(f_arready), 64'b10);
        @(negedge aclk); s_arready = 1'b0; m_arvalid = 2'b00; s_rvalid = 1'b1; m_rready = 2'b10; #1;
        chk("fp_rvalid1", 64'(f_rvalid), 64'b10);
        @(negedge aclk); idle_inputs(); m_awvalid = 2'b01; m_wvalid = 2'b01; m_arvalid = 2'b01;
        @(negedge aclk); #1;
        chk("fp_read_first", 64'({f_s_arvalid, f_s_awvalid, f_s_wvalid}), 64'b100);
        $display("fixed priority: read-first arvalid=%b awvalid=%b", f_s_arvalid, f_s_awvalid);

        do_reset("end");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
